// File: rtl/seg_letters_pkg.sv
// seg_letters_pkg: segment pattern constants, word geometry and encoder states
package seg_letters_pkg;
  localparam int LETTER_W     = 3;
  localparam int WORD_LETTERS = 4;
  localparam logic [6:0] SEG_P0    = 7'b0000010;
  localparam logic [6:0] SEG_P1    = 7'b1100000;
  localparam logic [6:0] SEG_P2    = 7'b0110001;
  localparam logic [6:0] SEG_P3    = 7'b1000010;
  localparam logic [6:0] SEG_P4    = 7'b0010000;
  localparam logic [6:0] SEG_P5    = 7'b0111000;
  localparam logic [6:0] SEG_P6    = 7'b0000100;
  localparam logic [6:0] SEG_P7    = 7'b1101000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {COLLECT, EMIT} enc_state_t;
endpackage

// File: rtl/seg_pattern_lookup.sv
// seg_pattern_lookup: active-low 7-segment pattern to 3-bit letter code, hit=0 when unrecognized
module seg_pattern_lookup
  import seg_letters_pkg::*;
(
  input  logic [6:0]          seg,
  output logic [LETTER_W-1:0] code,
  output logic                hit
);
  // decode table; unknown patterns (blank included) give code 0 with hit low
  always_comb begin
    code = '0;
    hit  = 1'b1;
    case (seg)
      SEG_P0:  code = 3'd0;
      SEG_P1:  code = 3'd1;
      SEG_P2:  code = 3'd2;
      SEG_P3:  code = 3'd3;
      SEG_P4:  code = 3'd4;
      SEG_P5:  code = 3'd5;
      SEG_P6:  code = 3'd6;
      SEG_P7:  code = 3'd7;
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_letter_encoder.sv
// seg_letter_encoder: assembles up to four decoded segment letters into a word; SEG_ERR_COUNT_EN adds err_count
module seg_letter_encoder
  import seg_letters_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_seg,
  input  logic        in_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [11:0] word_codes,
  output logic [2:0]  word_len,
  output logic        word_err
`ifdef SEG_ERR_COUNT_EN
  , output logic [7:0] err_count
`endif
);
  enc_state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [11:0] slots_q, slots_d;
  logic [2:0] len_q, len_d;
  logic err_q, err_d;
  logic alive_q;
  logic [LETTER_W-1:0] code;
  logic hit, acc;
  seg_pattern_lookup u_lookup (.seg(in_seg), .code(code), .hit(hit));
  assign in_ready   = alive_q && (state_q == COLLECT);
  assign word_valid = (state_q == EMIT);
  assign acc        = in_valid && in_ready;
  assign word_codes = slots_q;
  assign word_len   = len_q;
  assign word_err   = err_q;
  // store accepted letters, finish the word on in_last or the fourth letter, clear on handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slots_d = slots_q;
    len_d   = len_q;
    err_d   = err_q;
    if (acc) begin
      slots_d[LETTER_W*idx_q +: LETTER_W] = code;
      idx_d = idx_q + 2'd1;
      err_d = err_q | ~hit;
      if (in_last || idx_q == 2'd3) begin
        state_d = EMIT;
        len_d   = {1'b0, idx_q} + 3'd1;
      end
    end else if (word_valid && word_ready) begin
      state_d = COLLECT;
      idx_d   = '0;
      slots_d = '0;
      len_d   = '0;
      err_d   = 1'b0;
    end
  end
  // state registers; alive_q holds in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      slots_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slots_q <= slots_d;
      len_q   <= len_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign err_count = cnt_q;
  // saturating count of accepted unrecognized patterns, cleared only by reset
  always_comb cnt_d = (acc && !hit && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  // error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_seg_letter_encoder.sv
// tb_seg_letter_encoder: directed vectors checked against a word-level model every cycle
module tb_seg_letter_encoder;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_last = 1'b0, word_ready = 1'b0;
  logic [6:0] in_seg = 7'h7F;
  logic in_ready, word_valid, word_err;
  logic [11:0] word_codes;
  logic [2:0] word_len;
  int checks = 0, errors = 0;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count;
  localparam int N_BLANK = 300;
`else
  localparam int N_BLANK = 20;
`endif
  seg_letter_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_seg(in_seg), .in_last(in_last), .word_valid(word_valid), .word_ready(word_ready),
    .word_codes(word_codes), .word_len(word_len), .word_err(word_err)
`ifdef SEG_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  logic [6:0] pats [8] = '{7'b0000010, 7'b1100000, 7'b0110001, 7'b1000010,
                           7'b0010000, 7'b0111000, 7'b0000100, 7'b1101000};
  int m_codes [4] = '{0, 0, 0, 0};
  int m_n = 0, m_len = 0, m_cnt = 0;
  bit m_emit = 0, m_alive = 0, m_err = 0;
  function automatic int lk(input logic [6:0] s);
    for (int i = 0; i < 8; i++) if (s == pats[i]) return i;
    return -1;
  endfunction
  function automatic int packed_word();
    int w = 0;
    for (int i = 0; i < 4; i++) w += m_codes[i] * (1 << (3 * i));
    return w;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    int c;
    if (!rst_n) begin
      m_emit <= 0; m_alive <= 0; m_n <= 0; m_len <= 0; m_err <= 0; m_cnt <= 0;
      m_codes <= '{0, 0, 0, 0};
    end else begin
      m_alive <= 1;
      if (!m_emit && m_alive && in_valid) begin
        c = lk(in_seg);
        m_codes[m_n] <= (c < 0) ? 0 : c;
        m_n <= m_n + 1;
        if (c < 0) begin
          m_err <= 1;
          m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
        if (in_last || m_n == 3) begin
          m_emit <= 1;
          m_len <= m_n + 1;
        end
      end else if (m_emit && word_ready) begin
        m_emit <= 0; m_n <= 0; m_len <= 0; m_err <= 0;
        m_codes <= '{0, 0, 0, 0};
      end
    end
  end
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_alive && !m_emit});
    chk("word_valid", {31'd0, word_valid}, {31'd0, m_emit});
    if (m_emit) begin
      chk("word_codes", {20'd0, word_codes}, packed_word());
      chk("word_len", {29'd0, word_len}, m_len);
      chk("word_err", {31'd0, word_err}, {31'd0, m_err});
    end
`ifdef SEG_ERR_COUNT_EN
    chk("err_count", {24'd0, err_count}, m_cnt);
`endif
  end
  task automatic send(input logic [6:0] s, input logic last);
    in_valid = 1'b1; in_seg = s; in_last = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_seg = 7'h7F;
  endtask
  task automatic consume();
    word_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (word_valid) break;
    end
    chk("consume_wait", {31'd0, word_valid}, 32'd1);
    @(posedge clk); #1;
    word_ready = 1'b0;
  endtask
  initial begin
    logic [11:0] held;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_codes", {20'd0, word_codes}, 32'd0);
    chk("rst_len", {29'd0, word_len}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    send(7'b0000010, 0); send(7'b1100000, 0); send(7'b0110001, 0); send(7'b1000010, 0);
    chk("w4_valid", {31'd0, word_valid}, 32'd1);
    chk("w4_codes", {20'd0, word_codes}, {20'd0, 12'o3210});
    chk("w4_len", {29'd0, word_len}, 32'd4);
    chk("w4_err", {31'd0, word_err}, 32'd0);
    consume();
    chk("w4_back", {31'd0, in_ready}, 32'd1);
    send(7'b0010000, 1);
    chk("w1_codes", {20'd0, word_codes}, 32'h004);
    chk("w1_len", {29'd0, word_len}, 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("w1_hold_ready", {31'd0, in_ready}, 32'd0);
    consume();
    send(7'b1111111, 0); send(7'b1101000, 1);
    chk("w2_codes", {20'd0, word_codes}, 32'h038);
    chk("w2_len", {29'd0, word_len}, 32'd2);
    chk("w2_err", {31'd0, word_err}, 32'd1);
`ifdef SEG_ERR_COUNT_EN
    chk("w2_cnt", {24'd0, err_count}, 32'd1);
`endif
    consume();
    send(7'b0111000, 0); send(7'b0000100, 1);
    held = word_codes;
    chk("stall_codes", {20'd0, held}, 32'o065);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1; in_seg = pats[i]; in_last = i[1];
      @(posedge clk); #1;
      chk("stall_stable", {20'd0, word_codes}, {20'd0, held});
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    chk("stall_back", {31'd0, in_ready}, 32'd1);
    send(7'b1100000, 0); send(7'b0110001, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_codes", {20'd0, word_codes}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_valid", {31'd0, word_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(7'b1000010, 0); send(7'b0010000, 0); send(7'b0111000, 0); send(7'b0000100, 0);
    chk("post_rst_codes", {20'd0, word_codes}, {20'd0, 12'o6543});
    chk("post_rst_len", {29'd0, word_len}, 32'd4);
    consume();
    word_ready = 1'b1;
    for (int i = 0; i < N_BLANK; i++) send(7'b1111111, 1);
    @(posedge clk); #1 word_ready = 1'b0;
`ifdef SEG_ERR_COUNT_EN
    chk("cnt_sat", {24'd0, err_count}, 32'd255);
`endif
    repeat (2) @(posedge clk);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_letter_encoder.md
SEG_LETTER_ENCODER -- requirements
Module: seg_letter_encoder

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  in_seg and in_last are valid this cycle.
REQ-004 SHALL have port in_ready  output  1  block accepts a pattern this cycle.
REQ-005 SHALL have port in_seg  input  7  active-low segment pattern, bit6..bit0.
REQ-006 SHALL have port in_last  input  1  accepted pattern is the final letter of the word.
REQ-007 SHALL have port word_valid  output  1  assembled word is presented.
REQ-008 SHALL have port word_ready  input  1  consumer takes the word.
REQ-009 SHALL have port word_codes  output  12  four 3-bit letter codes; slot0 = [2:0], slot3 = [11:9].
REQ-010 SHALL have port word_len  output  3  number of letters in the word, 1..4.
REQ-011 SHALL have port word_err  output  1  the word contained at least one unrecognized pattern.
REQ-012 SHALL have port err_count  output  8  saturating count of unrecognized patterns; present only under the REQ-030 macro.

Function
REQ-013 SHALL map in_seg to a code via the decided table: 0000010->0, 1100000->1, 0110001->2, 1000010->3, 0010000->4, 0111000->5, 0000100->6, 1101000->7.
REQ-014 SHALL treat any other pattern, including blank 1111111, as unrecognized: store code 0 and set the sticky word error.
REQ-015 SHALL implement two states: COLLECT (reset state) and EMIT.
REQ-016 SHALL drive in_ready=1 and word_valid=0 in COLLECT, and in_ready=0 and word_valid=1 in EMIT.
REQ-017 SHALL accept a pattern only when in_valid && in_ready, then write its code to slot idx and increment idx.
REQ-018 SHALL go COLLECT->EMIT on the accepting cycle when in_last=1 or idx==3, giving word_valid the cycle after the final accept.
REQ-019 SHALL hold word_codes, word_len and word_err stable throughout EMIT.
REQ-020 SHALL go EMIT->COLLECT on word_valid && word_ready, clearing slots, idx and the sticky error in that same edge.
REQ-021 SHALL keep unused slots at 3'b000.
REQ-022 SHALL set word_len = idx+1 at the final accept; it is never 0 in EMIT.
REQ-023 SHALL ignore in_valid, in_seg and in_last while in EMIT; no pattern is lost because in_ready=0.
REQ-024 SHALL give a throughput of at most one word per (len+1) cycles when word_ready is held at 1.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=COLLECT, idx=0, slots=0, word_len=0, word_err=0, word_valid=0, in_ready=0, err_count=0.
REQ-026 SHALL, after rst_n deasserts, raise in_ready at the first clock edge.
REQ-027 SHALL discard a partially collected word on reset mid-word and a pending word on reset during EMIT.

Configuration
REQ-028 SHALL use the macro SEG_ERR_COUNT_EN.
REQ-029 SHALL, with the macro defined, increment err_count by 1 per accepted unrecognized pattern, saturate it at 255, and never clear it except on reset.
REQ-030 SHALL, without the macro, omit the err_count port and counter logic, with word_err still functional.

Structure
REQ-031 SHALL place the eight pattern constants, SEG_BLANK, LETTER_W=3 and WORD_LETTERS=4 in the shared package seg_letters_pkg.
REQ-032 SHALL implement the combinational lookup as sub-module seg_pattern_lookup (7-bit pattern in; 3-bit code and hit flag out).

Verification
REQ-033 SHALL test: patterns 0000010, 1100000, 0110001, 1000010 -> word_codes=12'o3210, word_len=4, word_err=0, word_valid one cycle after 4th accept.
REQ-034 SHALL test: 0010000 with in_last=1 -> word_codes=12'h004, word_len=1, in_ready=0 until word_ready.
REQ-035 SHALL test: 1111111, 1101000(last) -> slot0=0, slot1=7, word_len=2, word_err=1; with the macro, err_count=1.
REQ-036 SHALL test: word_ready held 0 for 5 cycles, in_valid toggling -> outputs stable, no pattern accepted, then one handshake returns to COLLECT.
REQ-037 SHALL test: rst_n pulsed low after 2 accepts -> outputs zero asynchronously; next 4-letter word is assembled from slot0.
REQ-038 SHALL test: with the macro, 300 unrecognized patterns -> err_count=255.
